quick_rs232_tx: RTL and testbench
=================================

Name: quick_rs232_tx

Overview:
- Standalone RS-232 transmitter; the counterpart of the quick_rs232 receive path.
- Serialises bytes as LSB-first frames: start bit, BYTE_LEN data bits, optional parity, then stop bit(s).
- Honours hardware flow control (peer CTS) and holds one byte in a buffer so back-to-back frames leave no idle gap.
- Used as the line driver in device designs and as the synthesizable peer/stimulus source for quick_rs232 benches.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate; BIT_TICKS = CLK_FREQ/BAUD_RATE (434 at defaults), integer-truncated.
- BYTE_LEN, 8, data bits per frame; legal range 5..8.
- PARITY, 1, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 0, 0 = one stop bit, 1 = one and a half, 2 = two.
- FLOW_CONTROL, 0, 0 = ignore cts, 1 = a frame may start only while synchronised cts is 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tx  out  1  serial line; idle level is 1.
- cts  in  1  peer clear-to-send; passes through a 2-FF synchroniser.
- tx_transaction  in  1  enable; while 0, no new frame starts.
- tx_data  in  8  byte to send; bits above BYTE_LEN-1 are ignored.
- tx_data_ready  in  1  rising edge offers tx_data.
- tx_data_copied  out  1  one-clock pulse when a byte is latched into the holding register.
- tx_busy  out  1  1 while a frame is in progress or the holding register is full.

Behaviour:
- Reset values: tx = 1, tx_data_copied = 0, tx_busy = 0; state IDLE; holding register empty; baud counter 0; synchroniser flops reset to 0.
- Reset mid-frame: tx returns to 1 asynchronously and the frame is abandoned; no truncated bits are resumed.
- Offer detection: tx_data_ready is registered. An offer is the condition ready = 1 at this edge and 0 at the previous edge.
  - Holding holding level high never produces a second copy.
- Accept (clock edge N): if an offer occurs and the holding register is empty, latch tx_data into holding. tx_data_copied is 1 for the single cycle following edge N.
- Offer while holding is full: dropped, no copied pulse. The producer must wait for tx_busy = 0 or for a copied pulse.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE, or STOP -> START directly.
- IDLE -> START: requires holding full, tx_transaction = 1, and (FLOW_CONTROL = 0 or cts_sync = 1).
  - At that edge the holding byte moves to the shift register, holding empties, and tx = 0 from the next cycle.
  - An accept and a move in the same edge are legal: holding is loaded with the new byte.
- Each bit lasts exactly BIT_TICKS clocks; the baud counter restarts at 0 on every state entry.
- DATA: shifts LSB first for BYTE_LEN bits.
- PARITY: skipped when PARITY = 0.
  - Even: parity bit = XOR of the data bits.
  - Odd: parity bit = inverse of that XOR.
- STOP: tx = 1. Duration is BIT_TICKS, BIT_TICKS + BIT_TICKS/2 (651 at defaults), or 2*BIT_TICKS according to STOP_BITS.
  - On STOP completion, go to START if the start condition holds, else IDLE.
- Ongoing frames always complete: tx_transaction or cts dropping mid-frame has no effect on the current frame. The holding byte is kept until the start condition holds again.
- tx_busy = (state != IDLE) | holding_full, registered.
- The baud counter is 16 bits, which is enough for 2*BIT_TICKS at CLK_FREQ/BAUD_RATE <= 32767. It never wraps within a bit.

Decomposition:
- Shared include quick_rs232_defs.vh holds:
  - parity codes: NONE, EVEN, ODD;
  - stop-bit codes: ONE, ONE_HALF, TWO;
  - state encodings;
  - the BIT_TICKS formula macro, so the receiver and transmitter use the same constants.
- One sub-module, quick_rs232_baud_gen: counts to a programmable limit with a restart input, outputs a bit_done pulse, and is reusable by the receiver.

Test Plan:
- Defaults (even parity): offer 8'b10001100, sample tx at mid-bit.
  - Required line sequence: 0 | 0,0,1,1,0,0,0,1 | parity 1 | stop 1, each bit 434 clocks.
  - tx_data_copied pulses exactly once.
- PARITY = 2, STOP_BITS = 2: send 8'h53.
  - Required: data 1,1,0,0,1,0,1,0, odd parity bit 1, tx high for 868 clocks before the next start.
- Back-to-back: offer 8'h55, then offer 8'hAA during its DATA phase.
  - Second copied pulse arrives immediately.
  - The second start bit begins on the clock right after the first stop bit; tx_busy stays 1 throughout.
- FLOW_CONTROL = 1 with cts = 0: offer 8'h12.
  - tx stays 1 and tx_busy = 1.
  - Raise cts: start bit appears 3 to 4 clocks later.
  - Drop cts mid-DATA: the frame still completes.
- Hold tx_data_ready high for 10 bit times: exactly one frame is sent and one copied pulse is produced.
- Assert rst during bit 3 of a frame: tx = 1 within the same cycle and tx_busy = 0. A new offer after reset transmits a full, correct frame.

Source files
------------

// File: rtl/quick_rs232_tx_pkg.sv
// Shared RS-232 constants: parity/stop codes, FSM encoding and bit-timing helpers,
// common to the transmitter and the quick_rs232 receive path.
package quick_rs232_tx_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int STOP_ONE      = 0;
  localparam int STOP_ONE_HALF = 1;
  localparam int STOP_TWO      = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rs232_state_e;

  function automatic int bit_ticks(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int stop_ticks(input int bit_t, input int stop_bits);
    case (stop_bits)
      STOP_ONE_HALF: return bit_t + bit_t / 2;
      STOP_TWO:      return 2 * bit_t;
      default:       return bit_t;
    endcase
  endfunction

endpackage

// File: rtl/quick_rs232_tx_if.sv
// Producer-side handshake and serial line of the RS-232 transmitter.
interface quick_rs232_tx_if;
  logic       tx;
  logic       cts;
  logic       tx_transaction;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_data_copied;
  logic       tx_busy;

  modport master (
    input  tx, tx_data_copied, tx_busy,
    output cts, tx_transaction, tx_data, tx_data_ready
  );

  modport slave (
    output tx, tx_data_copied, tx_busy,
    input  cts, tx_transaction, tx_data, tx_data_ready
  );
endinterface

// File: rtl/quick_rs232_baud_gen.sv
// Bit-period counter: counts 0..limit-1, pulses bit_done on the last tick and
// self-restarts; restart_i holds it at zero.
module quick_rs232_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart_i,
  input  logic [15:0] limit_i,
  output logic        bit_done_o
);
  logic [15:0] cnt_q, cnt_d;

  assign bit_done_o = ~restart_i & (cnt_q == limit_i - 16'd1);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (restart_i || bit_done_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/quick_rs232_tx.sv
// RS-232 transmitter: one-byte holding register feeding an LSB-first frame
// serialiser with optional parity, configurable stop length and CTS gating.
module quick_rs232_tx
  import quick_rs232_tx_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int BYTE_LEN     = 8,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 0,
  parameter int FLOW_CONTROL = 0
) (
  input  logic               clk,
  input  logic               rst,
  quick_rs232_tx_if.slave    bus
);
  localparam int         BIT_T     = bit_ticks(CLK_FREQ, BAUD_RATE);
  localparam int         STOP_T    = stop_ticks(BIT_T, STOP_BITS);
  localparam logic [7:0] DATA_MASK = 8'((1 << BYTE_LEN) - 1);
  localparam logic [2:0] LAST_BIT  = 3'(BYTE_LEN - 1);

  rs232_state_e state_q, state_d;
  logic         cts_meta_q, cts_sync_q, rdy_q;
  logic [7:0]   hold_q, hold_d, shift_q, shift_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic         hold_full_q, hold_full_d;
  logic         par_q, par_d, tx_q, tx_d, busy_q, busy_d, copied_q;
  logic         offer, accept, start_ok, move, restart, bit_done;
  logic [15:0]  limit;

  assign offer    = bus.tx_data_ready & ~rdy_q;
  assign start_ok = hold_full_q & bus.tx_transaction & ((FLOW_CONTROL == 0) | cts_sync_q);
  assign move     = start_ok & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_done));
  // the holding register frees up on the same edge it hands its byte to the shifter
  assign accept   = offer & (~hold_full_q | move);
  assign limit    = (state_q == ST_STOP) ? 16'(STOP_T) : 16'(BIT_T);

  quick_rs232_baud_gen u_baud (
    .clk        (clk),
    .rst        (rst),
    .restart_i  (restart),
    .limit_i    (limit),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    restart   = 1'b0;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tx_d      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        restart = 1'b1;
        if (move) state_d = ST_START;
      end
      ST_START:  if (bit_done) state_d = ST_DATA;
      ST_DATA: if (bit_done) begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
        end else begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      ST_PARITY: if (bit_done) state_d = ST_STOP;
      ST_STOP:   if (bit_done) state_d = move ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (move) begin
      shift_d   = hold_q & DATA_MASK;
      bit_cnt_d = '0;
      par_d     = (^(hold_q & DATA_MASK)) ^ (PARITY == PARITY_ODD);
    end
    hold_d      = accept ? bus.tx_data : hold_q;
    hold_full_d = accept | (hold_full_q & ~move);
    // line level is registered from next-state so it changes with the state
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE) | hold_full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cts_meta_q  <= 1'b0;
      cts_sync_q  <= 1'b0;
      rdy_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      copied_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cts_meta_q  <= bus.cts;
      cts_sync_q  <= cts_meta_q;
      rdy_q       <= bus.tx_data_ready;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      copied_q    <= accept;
    end
  end

  assign bus.tx             = tx_q;
  assign bus.tx_data_copied = copied_q;
  assign bus.tx_busy        = busy_q;
endmodule

// File: tb/tb_quick_rs232_tx.sv
// Bench for quick_rs232_tx: three configurations, frames checked bit-by-bit at mid-bit
// against a frame model built from byte, parity and stop rules.
module tb_quick_rs232_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quick_rs232_tx_if ifa ();
  quick_rs232_tx_if ifb ();
  quick_rs232_tx_if ifc ();

  quick_rs232_tx u_a (.clk(clk), .rst(rst), .bus(ifa));
  quick_rs232_tx #(.CLK_FREQ(2000), .BAUD_RATE(100), .BYTE_LEN(8), .PARITY(2),
                   .STOP_BITS(2), .FLOW_CONTROL(1))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  quick_rs232_tx #(.CLK_FREQ(1700), .BAUD_RATE(100), .BYTE_LEN(5), .PARITY(0),
                   .STOP_BITS(1), .FLOW_CONTROL(0))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  // per-instance frame rules: bit ticks, stop ticks, data bits, parity mode
  int BT[3]    = '{434, 20, 17};
  int STOPT[3] = '{434, 40, 25};
  int BL[3]    = '{8, 8, 5};
  int PAR[3]   = '{1, 2, 0};

  int   passed = 0, total = 0, failed = 0;
  int   cyc = 0;
  int   cp[3] = '{0, 0, 0};
  int   busy_bad[3] = '{0, 0, 0};
  logic mon[3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifa.tx_data_copied === 1'b1) cp[0] <= cp[0] + 1;
    if (ifb.tx_data_copied === 1'b1) cp[1] <= cp[1] + 1;
    if (ifc.tx_data_copied === 1'b1) cp[2] <= cp[2] + 1;
    if (mon[0] && ifa.tx_busy !== 1'b1) busy_bad[0] <= busy_bad[0] + 1;
    if (mon[1] && ifb.tx_busy !== 1'b1) busy_bad[1] <= busy_bad[1] + 1;
    if (mon[2] && ifc.tx_busy !== 1'b1) busy_bad[2] <= busy_bad[2] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int k);
    case (k) 0: return ifa.tx; 1: return ifb.tx; default: return ifc.tx; endcase
  endfunction
  function automatic logic busy_of(input int k);
    case (k) 0: return ifa.tx_busy; 1: return ifb.tx_busy; default: return ifc.tx_busy; endcase
  endfunction
  function automatic logic copied_of(input int k);
    case (k)
      0: return ifa.tx_data_copied;
      1: return ifb.tx_data_copied;
      default: return ifc.tx_data_copied;
    endcase
  endfunction

  task automatic put(input int k, input logic [7:0] d, input logic r);
    case (k)
      0: begin ifa.tx_data = d; ifa.tx_data_ready = r; end
      1: begin ifb.tx_data = d; ifb.tx_data_ready = r; end
      default: begin ifc.tx_data = d; ifc.tx_data_ready = r; end
    endcase
  endtask

  // frame model: index 0 start, then data LSB first, optional parity, then stop
  function automatic int nbits(input int k);
    return 2 + BL[k] + ((PAR[k] != 0) ? 1 : 0);
  endfunction
  function automatic int frame_len(input int k);
    return (nbits(k) - 1) * BT[k] + STOPT[k];
  endfunction
  function automatic logic exp_bit(input int k, input logic [7:0] d, input int i);
    int ones;
    ones = 0;
    if (i == 0) return 1'b0;
    if (i <= BL[k]) return d[i-1];
    if (PAR[k] != 0 && i == BL[k] + 1) begin
      for (int j = 0; j < BL[k]; j++) ones += int'(d[j]);
      return ((ones % 2) == 1) ^ (PAR[k] == 2);
    end
    return 1'b1;
  endfunction

  task automatic offer(input int k, input logic [7:0] d, output logic c);
    @(negedge clk); put(k, d, 1'b1);
    @(negedge clk); c = copied_of(k); put(k, d, 1'b0);
  endtask

  task automatic wait_start(input int k, input string tag, output int t0);
    int n;
    n = 0;
    while (tx_of(k) !== 1'b0 && n < 40 * BT[k]) begin @(negedge clk); n++; end
    t0 = cyc;
    chk({tag, " start"}, 32'(tx_of(k)), 32'd0);
  endtask

  task automatic check_frame(input int k, input logic [7:0] d, input string tag, output int t0);
    wait_start(k, tag, t0);
    if (tx_of(k) === 1'b0) begin
      repeat (BT[k] / 2) @(negedge clk);
      for (int i = 0; i < nbits(k); i++) begin
        if (i > 0) repeat (BT[k]) @(negedge clk);
        chk($sformatf("%s bit%0d", tag, i), 32'(tx_of(k)), 32'(exp_bit(k, d, i)));
      end
    end
  endtask

  task automatic wait_idle(input int k, input string tag);
    int n;
    n = 0;
    while (busy_of(k) !== 1'b0 && n < 40 * BT[k]) begin @(negedge clk); n++; end
    chk({tag, " idle busy"}, 32'(busy_of(k)), 32'd0);
    chk({tag, " idle tx"}, 32'(tx_of(k)), 32'd1);
  endtask

  task automatic b2b(input int k, input logic [7:0] d1, input logic [7:0] d2, input string tag);
    logic c1, c2;
    int   t1, t2, cp0, bb0;
    cp0 = cp[k]; bb0 = busy_bad[k];
    offer(k, d1, c1);
    chk({tag, " copied1"}, 32'(c1), 32'd1);
    mon[k] = 1'b1;
    fork
      check_frame(k, d1, {tag, " f1"}, t1);
      begin
        repeat (3 * BT[k]) @(negedge clk);
        offer(k, d2, c2);
        chk({tag, " copied2"}, 32'(c2), 32'd1);
      end
    join
    check_frame(k, d2, {tag, " f2"}, t2);
    mon[k] = 1'b0;
    chk({tag, " gap"}, 32'(t2 - t1), 32'(frame_len(k)));
    chk({tag, " busy held"}, 32'(busy_bad[k] - bb0), 32'd0);
    chk({tag, " copies"}, 32'(cp[k] - cp0), 32'd2);
    wait_idle(k, tag);
  endtask

  initial begin : main
    int         t, c0, n;
    logic       c, seen;
    logic [7:0] d;
    ifa.cts = 1'b1; ifa.tx_transaction = 1'b1; put(0, 8'h00, 1'b0);
    ifb.cts = 1'b0; ifb.tx_transaction = 1'b1; put(1, 8'h00, 1'b0);
    ifc.cts = 1'b1; ifc.tx_transaction = 1'b1; put(2, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(ifa.tx), 32'd1);
    chk("reset busy", 32'(ifa.tx_busy), 32'd0);
    chk("reset copied", 32'(ifa.tx_data_copied), 32'd0);
    chk("reset tx b", 32'(ifb.tx), 32'd1);
    chk("reset busy c", 32'(ifc.tx_busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single frame, even parity
    c0 = cp[0];
    offer(0, 8'b10001100, c);
    chk("t1 copied", 32'(c), 32'd1);
    chk("t1 busy", 32'(ifa.tx_busy), 32'd1);
    check_frame(0, 8'b10001100, "t1", t);
    wait_idle(0, "t1");
    chk("t1 copies", 32'(cp[0] - c0), 32'd1);

    b2b(0, 8'h55, 8'hAA, "b2b");

    // ready held high: one offer only
    d = 8'($urandom); c0 = cp[0];
    @(negedge clk); put(0, d, 1'b1);
    check_frame(0, d, "hold", t);
    seen = 1'b0;
    repeat (2 * 434) begin @(negedge clk); if (ifa.tx !== 1'b1) seen = 1'b1; end
    put(0, d, 1'b0);
    chk("hold no second frame", 32'(seen), 32'd0);
    chk("hold copies", 32'(cp[0] - c0), 32'd1);
    wait_idle(0, "hold");

    // reset in the middle of data bit 3 (chosen 0 so the async return to 1 is visible)
    d = 8'($urandom) & 8'hF7;
    offer(0, d, c);
    wait_start(0, "rst", t);
    repeat (4 * 434 + 217) @(negedge clk);
    chk("rst pre bit3", 32'(ifa.tx), 32'(exp_bit(0, d, 4)));
    rst = 1'b1;
    #1;
    chk("rst async tx", 32'(ifa.tx), 32'd1);
    chk("rst async busy", 32'(ifa.tx_busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    d = 8'($urandom); c0 = cp[0];
    offer(0, d, c);
    chk("rst new copied", 32'(c), 32'd1);
    check_frame(0, d, "rst new", t);
    wait_idle(0, "rst new");
    chk("rst new copies", 32'(cp[0] - c0), 32'd1);

    // flow control: cts low holds the byte
    offer(1, 8'h53, c);
    chk("fc copied", 32'(c), 32'd1);
    seen = 1'b0;
    repeat (100) begin @(negedge clk); if (ifb.tx !== 1'b1) seen = 1'b1; end
    chk("fc tx held", 32'(seen), 32'd0);
    chk("fc busy", 32'(ifb.tx_busy), 32'd1);
    ifb.cts = 1'b1; n = 0;
    while (ifb.tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("fc cts latency 3..4", 32'(n >= 3 && n <= 4), 32'd1);
    fork
      check_frame(1, 8'h53, "fc", t);
      begin repeat (60) @(negedge clk); ifb.cts = 1'b0; end
    join
    wait_idle(1, "fc");

    // tx_transaction low holds the byte
    ifb.cts = 1'b1; ifb.tx_transaction = 1'b0;
    d = 8'($urandom);
    offer(1, d, c);
    chk("trans copied", 32'(c), 32'd1);
    seen = 1'b0;
    repeat (100) begin @(negedge clk); if (ifb.tx !== 1'b1) seen = 1'b1; end
    chk("trans tx held", 32'(seen), 32'd0);
    chk("trans busy", 32'(ifb.tx_busy), 32'd1);
    ifb.tx_transaction = 1'b1;
    check_frame(1, d, "trans", t);
    wait_idle(1, "trans");

    for (int i = 0; i < 4; i++) b2b(1, 8'($urandom), 8'($urandom), $sformatf("rb%0d", i));
    for (int i = 0; i < 4; i++) b2b(2, 8'($urandom), 8'($urandom), $sformatf("rc%0d", i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
